// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - ID-stage stall/bubble/flush sequencer with SWAP two-issue handling
module hazard_sequencer #(
  parameter logic [3:0] ATYPE_OP  = 4'b0001,
  parameter logic [3:0] SWAP_FUNC = 4'b1111,
  parameter logic [3:0] LOAD_OP   = 4'b1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ID_ALUOP,
  input  logic [3:0]  ID_FunctionCode,
  input  logic [3:0]  ID_Rs,
  input  logic [3:0]  ID_Rt,
  input  logic [3:0]  EX_ALUOP,
  input  logic [3:0]  EX_Rd,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        SwapSecond,
  output logic [15:0] StallCount,
  output logic [7:0]  FlushCount
);

  typedef enum logic {
    RUN   = 1'b0,
    SWAP2 = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   load_use;
  logic   is_swap;

  // Hazard detection; R0 is compared like any other register.
  assign load_use = (EX_ALUOP == LOAD_OP) && ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));
  assign is_swap  = (ID_ALUOP == ATYPE_OP) && (ID_FunctionCode == SWAP_FUNC);

  // State register; reset abandons any half-issued SWAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pipeline controls; priority is branch, then load-use, then SWAP.
  // Controls are held at their idle values while reset is asserted so random
  // inputs during reset cannot flush or stall the pipeline.
  always_comb begin
    state_next = RUN;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    SwapSecond = 1'b0;
    if (reset_n) begin
      case (state)
        RUN: begin
          if (BranchTaken) begin
            // PC keeps writing so the branch target is fetched.
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end else if (is_swap) begin
            // First half issues into EX while SWAP stays in ID for the second half.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            state_next = SWAP2;
          end
        end
        SWAP2: begin
          // EX holds the SWAP first half, so load-use and SWAP detection do not apply.
          if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else begin
            SwapSecond = 1'b1;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= 16'd0;
      FlushCount <= 8'd0;
    end else begin
      if (!PCWrite && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
      if (IFIDFlush && (FlushCount != 8'hFF)) begin
        FlushCount <= FlushCount + 8'd1;
      end
    end
  end

endmodule
